// File: rtl/presettable_down_counter_pkg.sv
// Shared constants for the counter blocks: FSM state codes and default width.
package presettable_down_counter_pkg;
   localparam logic [0:0] ST_IDLE       = 1'b0;
   localparam logic [0:0] ST_RUN        = 1'b1;
   localparam int         DEFAULT_WIDTH = 4;
endpackage

// File: rtl/presettable_down_counter_down_cell.sv
// One counter bit: loadable T-type cell, falling-edge clocked, async active-high reset.
module down_cell (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q
);
   logic r_q;

   always_ff @(negedge clk or posedge reset) begin
      if (reset)     r_q <= 1'b0;
      else if (load) r_q <= d;
      else if (t)    r_q <= ~r_q;
   end

   assign q = r_q;
endmodule

// File: rtl/presettable_down_counter.sv
// Loadable down counter/timer with one-shot and auto-reload modes and a one-cycle done pulse.
module presettable_down_counter
   import presettable_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);
   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_reload;
   logic             r_mode;
   logic             r_done;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_cell_d;
   logic             w_cell_load;
   logic             w_active;
   logic             w_expire;
   logic             w_dec;

   // A load on the same edge wins over any count activity, so it masks expiry.
   assign w_active    = (r_state == ST_RUN) && en && !load;
   assign w_expire    = w_active && (w_q == WIDTH'(1));
   assign w_dec       = w_active && !w_expire;
   assign w_cell_load = load || w_expire;
   assign w_cell_d    = load ? load_value : (r_mode ? r_reload : '0);

   // Borrow chain: bit i toggles when decrementing and every lower bit is 0.
   assign w_t[0] = w_dec;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_borrow
         assign w_t[gi] = w_t[gi-1] && !w_q[gi-1];
      end
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         down_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (w_cell_load),
            .d     (w_cell_d[gi]),
            .t     (w_t[gi]),
            .q     (w_q[gi])
         );
      end
   endgenerate

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_reload <= '0;
         r_mode   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (load) begin
            r_reload <= load_value;
            r_mode   <= auto_reload;
            if (load_value == '0) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end else begin
               r_state <= ST_RUN;
            end
         end else if (w_expire) begin
            r_done <= 1'b1;
            if (!r_mode) r_state <= ST_IDLE;
         end
      end
   end

   assign q    = w_q;
   assign busy = (r_state == ST_RUN);
   assign done = r_done;
endmodule
